dice_roller: RTL and testbench

DICE_ROLLER -- requirements
Module: dice_roller

---
 rtl/dice_roller.sv | 272 +++++++++++++++++++++++++++
 tb/tb_dice_roller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller.sv
// -----------------------------------------------------------------------------
// dice_roller
//
// Two-dice roller driven by a single roll/stop push button.
//
// The raw button is synchronized and optionally debounced, and its rising
// edge becomes a one-cycle press pulse. A free-running 16-bit LFSR supplies
// the randomness. The first press starts ROLL, where both dice are reloaded
// from the LFSR once every ROLL_DIV clocks. Once MIN_ROLL updates have been
// shown, a later press freezes the dice in HOLD. Any further press starts a
// new roll.
//
// Parameters
//   DEBOUNCE_CYCLES  clocks the synchronized key must differ from the
//                    debounced level before the debounced level follows it
//                    (used only when DICE_DEBOUNCE_EN is defined)
//   ROLL_DIV         clocks between dice updates while rolling (1..65535)
//   MIN_ROLL         dice updates needed in ROLL before a stop is accepted
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   key_roll      in   raw active-high button, asynchronous to clk
//   dice1         out  die 1 value, 1..6
//   dice2         out  die 2 value, 1..6
//   sum           out  dice1 + dice2, 2..12 (combinational)
//   stop          out  high while holding a frozen result
//   rolling       out  high while rolling
//   result_valid  out  one-cycle pulse in the first clock of each hold
//
// Configuration macro
//   DICE_DEBOUNCE_EN  when defined, a counter-based debouncer sits between
//                     the synchronizer and the edge detector. When it is not
//                     defined, the debounced level is the synchronized level,
//                     and a raw key edge reaches the press pulse in 3 clocks.
// -----------------------------------------------------------------------------
module dice_roller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] ROLL_DIV        = 16'd2500,
  parameter logic [15:0] MIN_ROLL        = 16'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_roll,
  output logic [3:0] dice1,
  output logic [3:0] dice2,
  output logic [3:0] sum,
  output logic       stop,
  output logic       rolling,
  output logic       result_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Die mapping: d = (f mod 6) + 1 for a 3-bit field f.
  function automatic logic [3:0] map_die(input logic [2:0] f);
    logic [3:0] d;
    case (f)
      3'd6:    d = 4'd1;
      3'd7:    d = 4'd2;
      default: d = {1'b0, f} + 4'd1;
    endcase
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Key synchronizer: two flops before the key is used anywhere else.
  // ---------------------------------------------------------------------------
  logic sync_meta;
  logic key_sync;

  // NOTE: registers are written only with non-blocking assignments, so every
  // flop samples the values that were present before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b0;
      key_sync  <= 1'b0;
    end else begin
      sync_meta <= key_roll;
      key_sync  <= sync_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic key_deb;

`ifdef DICE_DEBOUNCE_EN
  logic [15:0] deb_cnt;

  // The count runs only while the synchronized key disagrees with the
  // debounced level. Any agreement restarts it, so only an uninterrupted run
  // of DEBOUNCE_CYCLES clocks moves the debounced level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt <= 16'd0;
      key_deb <= 1'b0;
    end else if (key_sync == key_deb) begin
      deb_cnt <= 16'd0;
    end else if (deb_cnt == DEBOUNCE_CYCLES - 16'd1) begin
      deb_cnt <= 16'd0;
      key_deb <= key_sync;
    end else begin
      deb_cnt <= deb_cnt + 16'd1;
    end
  end
`else
  logic unused_debounce_cycles;

  assign key_deb                = key_sync;
  assign unused_debounce_cycles = ^DEBOUNCE_CYCLES;
`endif

  // ---------------------------------------------------------------------------
  // Rising-edge detector: press is registered, so it appears in the cycle
  // after the debounced level rises. Falling edges produce nothing.
  // ---------------------------------------------------------------------------
  logic key_deb_q;
  logic press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_deb_q <= 1'b0;
      press     <= 1'b0;
    end else begin
      key_deb_q <= key_deb;
      press     <= key_deb & ~key_deb_q;
    end
  end

  // ---------------------------------------------------------------------------
  // LFSR: 16-bit Fibonacci form of x^16+x^14+x^13+x^11+1, right shift. It
  // free-runs in every state, so the frozen values depend on when the user
  // presses the button.
  // ---------------------------------------------------------------------------
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t      state;
  state_t      state_next;
  logic [15:0] div_cnt;
  logic [15:0] roll_cnt;
  logic        div_tc;
  logic        enter_roll;
  logic        load_dice;

  assign div_tc = (div_cnt == ROLL_DIV - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal assigned in this block gets a default value first, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    enter_roll = 1'b0;
    load_dice  = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          state_next = ROLL;
          enter_roll = 1'b1;
        end
      end
      ROLL: begin
        // An accepted stop takes priority over a coincident dice update, so
        // the frozen values are the ones on display when the user pressed.
        // An early press is dropped and rolling simply continues.
        if (press && (roll_cnt == MIN_ROLL)) begin
          state_next = HOLD;
        end else begin
          load_dice = div_tc;
        end
      end
      HOLD: begin
        if (press) begin
          state_next = ROLL;
          enter_roll = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Divider and roll counters. Both are cleared on every entry to ROLL and
  // advance only while the FSM stays in ROLL.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= 16'd0;
      roll_cnt <= 16'd0;
    end else if (enter_roll) begin
      div_cnt  <= 16'd0;
      roll_cnt <= 16'd0;
    end else if (load_dice || ((state == ROLL) && (state_next == ROLL))) begin
      div_cnt <= div_tc ? 16'd0 : div_cnt + 16'd1;
      if (div_tc && (roll_cnt != MIN_ROLL)) begin
        roll_cnt <= roll_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Dice registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dice1 <= 4'd1;
      dice2 <= 4'd1;
    end else if (load_dice) begin
      dice1 <= map_die(lfsr[2:0]);
      dice2 <= map_die(lfsr[10:8]);
    end
  end

  // result_valid is registered so it lines up with the first HOLD clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state_next == HOLD) && (state != HOLD);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sum     = dice1 + dice2;
  assign stop    = (state == HOLD);
  assign rolling = (state == ROLL);

  // ---------------------------------------------------------------------------
  // Embedded invariants
  // ---------------------------------------------------------------------------
  a_dice1_range : assert property (@(posedge clk) disable iff (!rst)
    (dice1 >= 4'd1) && (dice1 <= 4'd6));
  a_dice2_range : assert property (@(posedge clk) disable iff (!rst)
    (dice2 >= 4'd1) && (dice2 <= 4'd6));
  a_state_excl  : assert property (@(posedge clk) disable iff (!rst)
    !(stop && rolling));
  a_valid_hold  : assert property (@(posedge clk) disable iff (!rst)
    result_valid |-> stop);

endmodule

// File: tb/tb_dice_roller.sv
// -----------------------------------------------------------------------------
// tb_dice_roller
//
// Self-checking bench for dice_roller with DEBOUNCE_CYCLES=4, ROLL_DIV=3 and
// MIN_ROLL=10. A behavioural model advances on each rising edge and is
// compared with every DUT output on the falling edge. The model tracks the
// key as a level history, counts clocks spent rolling, and schedules a dice
// update whenever that count reaches a multiple of ROLL_DIV. Directed
// scenarios are followed by a phase of random key bursts.
// -----------------------------------------------------------------------------
module tb_dice_roller;

  localparam logic [15:0] DEB  = 16'd4;
  localparam logic [15:0] RDIV = 16'd3;
  localparam logic [15:0] MINR = 16'd10;

`ifdef DICE_DEBOUNCE_EN
  localparam int ACT = 7;  // edges from the first sampled key-high edge to the acting edge
`else
  localparam int ACT = 3;
`endif
  localparam int KEY_HOLD = 10;

  localparam int M_IDLE = 0;
  localparam int M_ROLL = 1;
  localparam int M_HOLD = 2;

  logic       clk;
  logic       rst;
  logic       key_roll;
  logic [3:0] dice1;
  logic [3:0] dice2;
  logic [3:0] sum;
  logic       stop;
  logic       rolling;
  logic       result_valid;

  dice_roller #(
    .DEBOUNCE_CYCLES(DEB),
    .ROLL_DIV       (RDIV),
    .MIN_ROLL       (MINR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_roll    (key_roll),
    .dice1       (dice1),
    .dice2       (dice2),
    .sum         (sum),
    .stop        (stop),
    .rolling     (rolling),
    .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int unsigned m_lfsr;
  int          m_s1, m_s2;      // key sampled one and two edges ago
  int          m_deb, m_run;    // debounced level, length of current disagreement
  int          m_lvl, m_lvl_prev;
  int          m_press;
  int          m_mode;
  int          m_roll_cycles;   // clocks spent in ROLL since entry
  int          m_updates;       // dice updates since entry to ROLL
  int          m_d1, m_d2;
  int          m_rv;

  function automatic int die(input int f);
    return (f % 6) + 1;
  endfunction

  task automatic model_reset();
    m_lfsr = 32'hACE1;
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_run = 0;
    m_lvl = 0; m_lvl_prev = 0; m_press = 0;
    m_mode = M_IDLE; m_roll_cycles = 0; m_updates = 0;
    m_d1 = 1; m_d2 = 1; m_rv = 0;
  endtask

  task automatic model_step();
    int mode_new, press_new, lvl_new, s2_old, bit_in;
    if (!rst) begin
      model_reset();
      return;
    end
    // Game behaviour, driven by the press pulse visible before this edge.
    mode_new = m_mode;
    if (m_mode == M_ROLL) begin
      if (m_press != 0 && m_updates >= int'(MINR)) begin
        mode_new = M_HOLD;
      end else begin
        if ((m_roll_cycles + 1) % int'(RDIV) == 0) begin
          m_d1 = die(int'(m_lfsr % 8));
          m_d2 = die(int'((m_lfsr / 256) % 8));
          m_updates++;
        end
        m_roll_cycles++;
      end
    end else if (m_press != 0) begin
      mode_new      = M_ROLL;
      m_roll_cycles = 0;
      m_updates     = 0;
    end
    m_rv   = (mode_new == M_HOLD && m_mode != M_HOLD) ? 1 : 0;
    m_mode = mode_new;

    // LFSR: Fibonacci x^16+x^14+x^13+x^11+1, right shift.
    bit_in = int'(((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1);
    m_lfsr = (m_lfsr >> 1) | (32'(bit_in) << 15);

    // Key path.
    s2_old = m_s2;
    m_s2   = m_s1;
    m_s1   = int'(key_roll);
`ifdef DICE_DEBOUNCE_EN
    if (s2_old != m_deb) begin
      m_run++;
      if (m_run == int'(DEB)) begin
        m_deb = s2_old;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    lvl_new = m_deb;
`else
    lvl_new = m_s2;
`endif
    press_new  = (m_lvl == 1 && m_lvl_prev == 0) ? 1 : 0;
    m_lvl_prev = m_lvl;
    m_lvl      = lvl_new;
    m_press    = press_new;
  endtask

  function automatic logic [31:0] expected_outs();
    logic [3:0] d1, d2, s;
    d1 = 4'(m_d1);
    d2 = 4'(m_d2);
    s  = 4'(m_d1 + m_d2);
    return {17'd0, d1, d2, s, m_mode == M_HOLD, m_mode == M_ROLL, m_rv != 0};
  endfunction

  // One clock: the model advances at the rising edge, outputs are compared at
  // the falling edge, and the caller may change inputs afterwards.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("outputs", {17'd0, dice1, dice2, sum, stop, rolling, result_valid}, expected_outs());
    check("dice_range", {31'd0, dice1 >= 4'd1 && dice1 <= 4'd6 && dice2 >= 4'd1 && dice2 <= 4'd6}, 32'd1);
  endtask

  task automatic press_key();
    key_roll = 1'b1;
    repeat (KEY_HOLD) tick();
    key_roll = 1'b0;
    repeat (KEY_HOLD) tick();
  endtask

  task automatic wait_updates(input int target);
    int n;
    n = 0;
    while (!(m_mode == M_ROLL && m_updates >= target) && n < 2000) begin
      tick();
      n++;
    end
    check("wait_rolling", {31'd0, rolling}, 32'd1);
  endtask

  task automatic press_until_stop();
    int n;
    n = 0;
    key_roll = 1'b1;
    while (!stop && n < 40) begin
      tick();
      n++;
    end
    check("stop_seen", {31'd0, stop}, 32'd1);
    check("rv_first", {31'd0, result_valid}, 32'd1);
    tick();
    check("rv_one_clock", {31'd0, result_valid}, 32'd0);
    key_roll = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, {17'd0, dice1, dice2, sum, stop, rolling, result_valid},
          {17'd0, 4'd1, 4'd1, 4'd2, 3'b000});
  endtask

  initial begin
    int n, rv_seen;
    logic [7:0] held, pre;

    rst      = 1'b0;
    key_roll = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outs("reset_state");
    rst = 1'b1;

    // Idle with no key.
    rv_seen = 0;
    repeat (100) begin
      tick();
      if (result_valid) rv_seen++;
    end
    check_reset_outs("idle_outputs");
    check("idle_rv_never", 32'(rv_seen), 32'd0);

`ifdef DICE_DEBOUNCE_EN
    // A short glitch must not register as a press.
    key_roll = 1'b1;
    repeat (3) tick();
    key_roll = 1'b0;
    repeat (12) tick();
    check("glitch_ignored", {31'd0, rolling}, 32'd0);
`endif

    // Start rolling.
    repeat ($urandom_range(0, 5)) tick();
    press_key();
    check("roll_started", {31'd0, rolling}, 32'd1);

    // An early stop press is dropped.
    wait_updates(5);
    press_key();
    check("early_press_rolling", {31'd0, rolling}, 32'd1);
    check("early_press_stop", {31'd0, stop}, 32'd0);

    // An accepted stop freezes the dice for 200 clocks.
    wait_updates(12);
    press_until_stop();
    held = {4'(m_d1), 4'(m_d2)};
    repeat (200) tick();
    check("hold_dice", {24'd0, dice1, dice2}, {24'd0, held});
    check("hold_sum", {28'd0, sum}, 32'(held[7:4] + held[3:0]));

    // A stop press that coincides with a divider terminal count.
    press_key();
    wait_updates(int'(MINR));
    n = 0;
    while (((m_roll_cycles + ACT) % int'(RDIV)) != int'(RDIV) - 1 && n < 10) begin
      tick();
      n++;
    end
    key_roll = 1'b1;
    pre = {4'(m_d1), 4'(m_d2)};
    n = 0;
    while (!stop && n < 40) begin
      pre = {4'(m_d1), 4'(m_d2)};
      tick();
      n++;
    end
    check("coincide_stop", {31'd0, stop}, 32'd1);
    check("coincide_frozen", {24'd0, dice1, dice2}, {24'd0, pre});
    key_roll = 1'b0;
    repeat (KEY_HOLD) tick();

    // Reset between clock edges while rolling.
    press_key();
    repeat (4) tick();
    check("pre_reset_rolling", {31'd0, rolling}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outs("async_reset");
    model_reset();
    repeat (2) tick();
    rst = 1'b1;
    repeat (20) tick();
    check("post_reset_idle", {31'd0, rolling}, 32'd0);
    press_key();
    check("post_reset_roll", {31'd0, rolling}, 32'd1);

    // From HOLD a press restarts rolling, and the roll count starts over.
    wait_updates(int'(MINR));
    press_until_stop();
    repeat (5) tick();
    key_roll = 1'b1;
    n = 0;
    while (!rolling && n < 40) begin
      tick();
      n++;
    end
    check("rehold_rolling", {31'd0, rolling}, 32'd1);
    check("rehold_stop_low", {31'd0, stop}, 32'd0);
    key_roll = 1'b0;
    repeat (KEY_HOLD) tick();
    press_key();
    check("restart_count_drop", {31'd0, stop}, 32'd0);
    wait_updates(int'(MINR));
    press_until_stop();

    // Random key bursts against the model.
    for (int i = 0; i < 40; i++) begin
      key_roll = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) tick();
    end
    key_roll = 1'b0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
